// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the processor control FSM.
// master = control-FSM side; slave = interrupt controller.
interface interrupt_controller_if;
  logic [7:0] HardwareInterrupt;
  logic       InstrBoundary;
  logic       IntAck;
  logic       IntReturn;
  logic       MaskWrite;
  logic [7:0] MaskData;
  logic       InterruptIn;
  logic [2:0] IntVector;
  logic       InterruptTrue;
  logic [7:0] Pending;
  logic [7:0] Mask;

  modport master (
    output HardwareInterrupt, InstrBoundary, IntAck, IntReturn, MaskWrite, MaskData,
    input  InterruptIn, IntVector, InterruptTrue, Pending, Mask
  );

  modport slave (
    input  HardwareInterrupt, InstrBoundary, IntAck, IntReturn, MaskWrite, MaskData,
    output InterruptIn, IntVector, InterruptTrue, Pending, Mask
  );
endinterface

// File: rtl/interrupt_controller.sv
// 8-line edge-triggered interrupt controller, fixed priority (bit 0 highest), no nesting.
// Define INT_SYNC_EN to add a 2-flop synchronizer on every line ahead of edge detection.
module interrupt_controller (
  input  logic                   CLK,
  input  logic                   Reset,
  interrupt_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVICE = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] line;
  logic [7:0] prev_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q;
  logic [2:0] vector_q, vector_d;
  logic [7:0] eligible;
  logic [7:0] ack_clear;
  logic [2:0] grant_idx;

`ifdef INT_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.HardwareInterrupt;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;
`else
  assign line = bus.HardwareInterrupt;
`endif

  assign eligible = pending_q & mask_q;

  // Lowest eligible index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    grant_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) grant_idx = 3'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state_q;
    vector_d  = vector_q;
    ack_clear = '0;
    case (state_q)
      IDLE: begin
        if (eligible != 8'h00 && bus.InstrBoundary) begin
          state_d  = REQUEST;
          vector_d = grant_idx;
        end
      end
      REQUEST: begin
        if (bus.IntAck) begin
          state_d             = SERVICE;
          ack_clear[vector_q] = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.IntReturn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new rising edge on the bit being acknowledged keeps it pending.
  assign pending_d = (pending_q & ~ack_clear) | (line & ~prev_q);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      vector_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      prev_q    <= line;
      pending_q <= pending_d;
      vector_q  <= vector_d;
      if (bus.MaskWrite) mask_q <= bus.MaskData;
    end
  end

  // Status outputs decode the state register, so reset drops them without a clock.
  assign bus.InterruptIn   = (state_q == REQUEST);
  assign bus.InterruptTrue = (state_q == SERVICE);
  assign bus.IntVector     = vector_q;
  assign bus.Pending       = pending_q;
  assign bus.Mask          = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (default build, no synchronizer).
module tb_interrupt_controller;
  logic CLK;
  logic Reset;
  int   compared;
  int   mismatched;

  interrupt_controller_if bus ();

  interrupt_controller dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and land 1 time unit after it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset                 = 1'b1;
    bus.HardwareInterrupt = 8'h00;
    bus.InstrBoundary     = 1'b0;
    bus.IntAck            = 1'b0;
    bus.IntReturn         = 1'b0;
    bus.MaskWrite         = 1'b0;
    bus.MaskData          = 8'h00;
    #1;
    check("rst_pending", bus.Pending, 8'h00);
    check("rst_mask", bus.Mask, 8'h00);
    check("rst_int_in", 8'(bus.InterruptIn), 8'h00);
    check("rst_int_true", 8'(bus.InterruptTrue), 8'h00);
    check("rst_vector", 8'(bus.IntVector), 8'h00);
    step(2);
    Reset = 1'b0;

    // Basic flow on line 3
    bus.MaskWrite = 1'b1; bus.MaskData = 8'hFF;
    step();
    check("mask_ff", bus.Mask, 8'hFF);
    bus.MaskWrite = 1'b0;
    bus.InstrBoundary = 1'b1;
    bus.HardwareInterrupt = 8'h08;
    step();
    check("l3_pending", bus.Pending, 8'h08);
    check("l3_no_req_yet", 8'(bus.InterruptIn), 8'h00);
    bus.HardwareInterrupt = 8'h00;
    step();
    check("l3_req", 8'(bus.InterruptIn), 8'h01);
    check("l3_vec", 8'(bus.IntVector), 8'h03);
    step();
    check("l3_req_held", 8'(bus.InterruptIn), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("l3_ack_pending", bus.Pending, 8'h00);
    check("l3_in_service", 8'(bus.InterruptTrue), 8'h01);
    check("l3_req_drop", 8'(bus.InterruptIn), 8'h00);
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    check("l3_ret_true", 8'(bus.InterruptTrue), 8'h00);
    check("l3_ret_req", 8'(bus.InterruptIn), 8'h00);

    // Stray ack in IDLE ignored
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("stray_ack", 8'(bus.InterruptTrue), 8'h00);

    // Simultaneous lines 5 and 2
    bus.HardwareInterrupt = 8'h24;
    step();
    check("l52_pending", bus.Pending, 8'h24);
    bus.HardwareInterrupt = 8'h00;
    step();
    check("l52_vec2", 8'(bus.IntVector), 8'h02);
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    check("ret_in_request", 8'(bus.InterruptIn), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("l2_ack_pending", bus.Pending, 8'h20);
    check("l2_service", 8'(bus.InterruptTrue), 8'h01);
    bus.InstrBoundary = 1'b0;
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    check("l2_ret", 8'(bus.InterruptTrue), 8'h00);
    step();
    check("no_boundary_no_grant", 8'(bus.InterruptIn), 8'h00);
    bus.InstrBoundary = 1'b1;
    step();
    check("l5_req", 8'(bus.InterruptIn), 8'h01);
    check("l5_vec", 8'(bus.IntVector), 8'h05);
    bus.HardwareInterrupt = 8'h01;
    step();
    bus.HardwareInterrupt = 8'h00;
    check("l0_during_req_pending", bus.Pending, 8'h21);
    check("vec_stable", 8'(bus.IntVector), 8'h05);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("l5_ack_pending", bus.Pending, 8'h01);
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    check("l5_ret", 8'(bus.InterruptIn), 8'h00);
    step();
    check("l0_regrant_vec", 8'(bus.IntVector), 8'h00);
    check("l0_regrant_req", 8'(bus.InterruptIn), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    check("l0_done_pending", bus.Pending, 8'h00);

    // Masking
    bus.MaskWrite = 1'b1; bus.MaskData = 8'h00;
    step();
    bus.MaskWrite = 1'b0;
    bus.HardwareInterrupt = 8'h01;
    step();
    bus.HardwareInterrupt = 8'h00;
    check("masked_pending", bus.Pending, 8'h01);
    step(2);
    check("masked_no_req", 8'(bus.InterruptIn), 8'h00);
    bus.MaskWrite = 1'b1; bus.MaskData = 8'h01;
    step();
    bus.MaskWrite = 1'b0;
    check("mask_01", bus.Mask, 8'h01);
    check("old_mask_used", 8'(bus.InterruptIn), 8'h00);
    step();
    check("unmask_grant", 8'(bus.InterruptIn), 8'h01);
    bus.MaskWrite = 1'b1; bus.MaskData = 8'h00;
    step();
    bus.MaskWrite = 1'b0;
    check("mask_keeps_req", 8'(bus.InterruptIn), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    bus.MaskWrite = 1'b1; bus.MaskData = 8'hFF;
    step();
    bus.MaskWrite = 1'b0;

    // Line 4 re-rises in its own ack cycle
    bus.HardwareInterrupt = 8'h10;
    step();
    bus.HardwareInterrupt = 8'h00;
    step();
    check("l4_vec", 8'(bus.IntVector), 8'h04);
    bus.IntAck = 1'b1;
    bus.HardwareInterrupt = 8'h10;
    step();
    bus.IntAck = 1'b0;
    bus.HardwareInterrupt = 8'h00;
    check("l4_set_wins", bus.Pending, 8'h10);
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    step();
    check("l4_regrant", 8'(bus.InterruptIn), 8'h01);
    check("l4_regrant_vec", 8'(bus.IntVector), 8'h04);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;

    // Line 7 held high: single event
    bus.HardwareInterrupt = 8'h80;
    step();
    check("l7_pending", bus.Pending, 8'h80);
    step();
    check("l7_vec", 8'(bus.IntVector), 8'h07);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("l7_acked", bus.Pending, 8'h00);
    step(7);
    check("l7_held_no_repeat", bus.Pending, 8'h00);
    bus.HardwareInterrupt = 8'h00;
    bus.IntReturn = 1'b1;
    step();
    bus.IntReturn = 1'b0;
    step();
    check("l7_fall_no_event", bus.Pending, 8'h00);
    check("l7_idle", 8'(bus.InterruptIn), 8'h00);

    // Async reset mid-SERVICE
    bus.HardwareInterrupt = 8'h02;
    step();
    bus.HardwareInterrupt = 8'h00;
    step();
    bus.IntAck = 1'b1;
    bus.HardwareInterrupt = 8'h08;
    step();
    bus.IntAck = 1'b0;
    bus.HardwareInterrupt = 8'h00;
    check("pre_rst_service", 8'(bus.InterruptTrue), 8'h01);
    check("pre_rst_pending", bus.Pending, 8'h08);
    Reset = 1'b1;
    #1;
    check("async_rst_true", 8'(bus.InterruptTrue), 8'h00);
    check("async_rst_pending", bus.Pending, 8'h00);
    check("async_rst_mask", bus.Mask, 8'h00);
    check("async_rst_vec", 8'(bus.IntVector), 8'h00);

    // Line held through reset release
    bus.HardwareInterrupt = 8'h40;
    step();
    Reset = 1'b0;
    step();
    check("held_thru_rst", bus.Pending, 8'h40);
    step(2);
    check("held_masked_no_req", 8'(bus.InterruptIn), 8'h00);
    bus.HardwareInterrupt = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
